// File: rtl/csa_add_sequencer.sv
// csa_add_sequencer: walks wide add/sub operands through a narrow adder slice, LSB slice first.
module csa_add_sequencer #(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               sub,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic               add_cin,
  input  logic [SLICE_W-1:0] add_sum,
  input  logic               add_cout,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               carry_out,
  output logic               overflow
);
  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int BW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [BW-1:0] LAST = BW'(NSLICE - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic sub_q, sub_d, carry_q, carry_d, carry_out_q, carry_out_d;
  logic overflow_q, overflow_d, done_q, done_d;
  logic [SLICE_W-1:0] a_s [NSLICE];
  logic [SLICE_W-1:0] b_s [NSLICE];
  logic run, last;
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    assign a_s[i] = a_q[i*SLICE_W +: SLICE_W];
    assign b_s[i] = b_q[i*SLICE_W +: SLICE_W];
  end
  assign run = state_q == RUN;
  assign last = beat_q == LAST;
  assign add_a = run ? a_s[beat_q] : '0;
  assign add_b = run ? b_s[beat_q] ^ {SLICE_W{sub_q}} : '0;
  assign add_cin = run & (beat_q == '0 ? sub_q : carry_q);
  assign busy = run;
  assign done = done_q;
  assign result = result_q;
  assign carry_out = carry_out_q;
  assign overflow = overflow_q;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    a_d = a_q;
    b_d = b_q;
    sub_d = sub_q;
    carry_d = carry_q;
    result_d = result_q;
    carry_out_d = carry_out_q;
    overflow_d = overflow_q;
    done_d = done_q;
    if (ena) begin
      done_d = 1'b0;
      if (!run && start) begin
        a_d = op_a;
        b_d = op_b;
        sub_d = sub;
        beat_d = '0;
        state_d = RUN;
      end else if (run) begin
        result_d[beat_q*SLICE_W +: SLICE_W] = add_sum;
        carry_d = add_cout;
        beat_d = last ? '0 : beat_q + 1'b1;
        if (last) begin
          // signed overflow: operands agree in sign but the sum does not
          carry_out_d = add_cout;
          overflow_d = (a_q[DATA_W-1] == (b_q[DATA_W-1] ^ sub_q)) & (add_sum[SLICE_W-1] != a_q[DATA_W-1]);
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      carry_q <= 1'b0;
      result_q <= '0;
      carry_out_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      a_q <= a_d;
      b_q <= b_d;
      sub_q <= sub_d;
      carry_q <= carry_d;
      result_q <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q <= overflow_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_csa_add_sequencer.sv
// tb_csa_add_sequencer: directed vectors against a behavioural 8-bit adder slice.
module tb_csa_add_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0, sub = 1'b0;
  logic [15:0] op_a = '0, op_b = '0, result;
  logic [7:0] add_a, add_b, add_sum;
  logic add_cin, add_cout, busy, done, carry_out, overflow;
  logic last_cin;
  int checks = 0, failures = 0, n;
  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
  csa_add_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    op_a = a;
    op_b = b;
    sub = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int from, output int cnt);
    cnt = from;
    while (!done && cnt < 20) begin
      if (busy) last_cin = add_cin;
      @(negedge clk);
      cnt++;
    end
  endtask
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] r, input logic c, input logic v);
    issue(a, b, s);
    wait_done(0, n);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_res"}, {c, v, busy, result}, {c, v, 1'b0, r});
  endtask
  initial begin
    #1;
    chk("rst_out", {busy, done, carry_out, overflow, add_cin, add_a, add_b, result}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("add1", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    chk("add1_cin1", last_cin, 1);
    @(negedge clk);
    chk("done_clr", done, 0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    // start during RUN is ignored; start in the done cycle is accepted
    issue(16'h1111, 16'h2222, 1'b0);
    op_a = 16'hFFFF;
    op_b = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n);
    chk("ign_lat", n, 2);
    chk("ign_res", result, 16'h3333);
    issue(16'h0100, 16'h0200, 1'b0);
    chk("b2b_busy", busy, 1);
    wait_done(0, n);
    chk("b2b_lat", n, 2);
    chk("b2b_res", result, 16'h0300);
    // ena stall mid-RUN
    issue(16'h00FF, 16'h0001, 1'b0);
    chk("ena_a0", add_a, 8'hFF);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    chk("ena_frz", {busy, done, add_a, add_b, add_cin, result}, {1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 16'h0300});
    ena = 1'b1;
    wait_done(3, n);
    chk("ena_lat", n, 5);
    chk("ena_res", result, 16'h0100);
    // async reset mid-RUN
    @(negedge clk);
    issue(16'h1234, 16'h4321, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", {busy, done, carry_out, overflow, add_cin, add_a, add_b, result}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(done | busy);
    end
    chk("arst_idle", n, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
